grf_sb: RTL

//  Parametrised successor to the single-cycle general register file, for the pipelined core.
//  - NUM_RD combinational read ports with write-to-read bypass.
//  - Per-register busy scoreboard for hazard detection.
//  - Multi-cycle sweep-clear after reset, so no initial block and no wide one-cycle clear.
//  - Sits between decode (reads, busy query, busy set) and writeback (write, busy clear).

---
 rtl/grf_sb.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/grf_sb.sv
// ============================================================================
// Module      : grf_sb
// Description : Parametrised general register file for the pipelined core.
//               NUM_RD combinational read ports with write-to-read bypass,
//               per-register busy scoreboard, multi-cycle sweep-clear after
//               reset. Optional write trace under macro GRF_TRACE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module grf_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       we,
    input  logic [ADDR_W-1:0]          wa,
    input  logic [DATA_W-1:0]          wd,
    input  logic [31:0]                wpc,
    input  logic [NUM_RD*ADDR_W-1:0]   ra,
    output logic [NUM_RD*DATA_W-1:0]   rd,
    output logic [NUM_RD-1:0]          rbusy,
    input  logic                       bset,
    input  logic [ADDR_W-1:0]          bset_a,
    output logic                       ready
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] C_LAST_IDX = {ADDR_W{1'b1}};

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_W-1:0]      idx_q,   idx_d;
    logic [DEPTH-1:0]       busy_q,  busy_d;
    logic                   ready_q, ready_d;
    logic [DATA_W-1:0]      regs_q [DEPTH];
    logic [DATA_W-1:0]      regs_d [DEPTH];

    logic                   run;
    logic                   wr_ok;

    assign run   = (state_q == RUN);
    assign wr_ok = run && we && (wa != '0);
    assign ready = ready_q;

    // ------------------------------------------------------------------
    // Sweep FSM: INIT clears one entry per cycle, then parks in RUN.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ready_d = ready_q;
        case (state_q)
            INIT: begin
                if (idx_q == C_LAST_IDX) begin
                    state_d = RUN;
                    ready_d = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            RUN: begin
                state_d = RUN;
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Storage next-state: sweep clear in INIT, writeback in RUN.
    // ------------------------------------------------------------------
    always_comb begin
        regs_d = regs_q;
        if (!reset) begin
            if (state_q == INIT) begin
                regs_d[idx_q] = '0;
            end else if (wr_ok) begin
                regs_d[wa] = wd;
            end
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard: set after clear so a new producer wins over writeback.
    // ------------------------------------------------------------------
    always_comb begin
        busy_d = busy_q;
        if (run) begin
            if (wr_ok) begin
                busy_d[wa] = 1'b0;
            end
            if (bset && (bset_a != '0)) begin
                busy_d[bset_a] = 1'b1;
            end
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= INIT;
            idx_q   <= '0;
            busy_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
        end
    end

    always_ff @(posedge clk) begin
        regs_q <= regs_d;
    end

`ifdef GRF_TRACE_EN
    always_ff @(posedge clk) begin
        if (!reset && wr_ok) begin
            $display("@%h: $%d <= %h", wpc, wa, wd);
        end
    end
`else
    logic unused_wpc;
    assign unused_wpc = ^wpc;
`endif

    // ------------------------------------------------------------------
    // Read ports: zero register, same-cycle bypass, then storage.
    // ------------------------------------------------------------------
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] port_a;
        logic [DATA_W-1:0] port_d;
        logic              port_b;
        logic              hit;

        assign port_a = ra[k*ADDR_W +: ADDR_W];
        assign hit    = we && (wa == port_a);

        always_comb begin
            port_d = '0;
            port_b = 1'b0;
            if (run && (port_a != '0)) begin
                port_d = hit ? wd : regs_q[port_a];
                port_b = busy_q[port_a] && !hit;
            end
        end

        assign rd[k*DATA_W +: DATA_W] = port_d;
        assign rbusy[k]               = port_b;
    end

endmodule

`default_nettype wire
